// File: rtl/rv32i_top.sv
// Single-cycle RV32I core with internal IMEM/DMEM; every instruction retires at the next clk edge (CPI 1).
// No flow control or stalls; define RV32I_TRACE_EN to print one $display line per retired write or store.
module rv32i_top #(
  parameter int    IMEM_DEPTH = 1024,
  parameter int    DMEM_DEPTH = 1024,
  parameter string IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst_n
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // The reset port name is historical; it is active-high.
  logic rst;
  assign rst = rst_n;

  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
  end

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign inst   = imem[pc[IA+1:2]];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic is_op, is_store;
  assign is_op    = (opcode == OPC_OP);
  assign is_store = (opcode == OPC_STORE);

  // ALU shared by OP and OP-IMM; inst[30] selects SUB only for register ops, SRA for both.
  logic [31:0] op_b, alu_res;
  logic [4:0]  shamt;
  assign op_b  = is_op ? rs2_val : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'd0: alu_res = (is_op && inst[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'd1: alu_res = rs1_val << shamt;
      3'd2: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'd3: alu_res = {31'd0, rs1_val < op_b};
      3'd4: alu_res = rs1_val ^ op_b;
      3'd5: alu_res = inst[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu_res = rs1_val | op_b;
      3'd7: alu_res = rs1_val & op_b;
      default: alu_res = '0;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0: br_taken = (rs1_val == rs2_val);
      3'd1: br_taken = (rs1_val != rs2_val);
      3'd4: br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: br_taken = (rs1_val < rs2_val);
      3'd7: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // rs1+imm_i serves both load addressing and the JALR target.
  logic [31:0] addr_i, mem_addr, rdata, load_val, st_data;
  logic [DA-1:0] widx;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign addr_i   = rs1_val + imm_i;
  assign mem_addr = is_store ? rs1_val + imm_s : addr_i;
  assign widx     = mem_addr[DA+1:2];
  assign rdata    = dmem[widx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:DA+2];

  always_comb begin
    ld_byte = rdata[7:0];
    case (mem_addr[1:0])
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = mem_addr[1] ? rdata[31:16] : rdata[15:0];
    load_val = rdata;
    case (funct3)
      3'd0: load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1: load_val = {{16{ld_half[15]}}, ld_half};
      3'd4: load_val = {24'd0, ld_byte};
      3'd5: load_val = {16'd0, ld_half};
      default: load_val = rdata;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    st_be   = 4'b1111;
    st_data = rs2_val;
    case (funct3[1:0])
      2'd0: begin
        st_be   = 4'b0001 << mem_addr[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      2'd1: begin
        st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_val;
      end
    endcase
  end

  logic        rd_we;
  logic [31:0] wd, pc_plus4, pc_next;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    rd_we   = 1'b0;
    wd      = '0;
    pc_next = pc_plus4;
    case (opcode)
      OPC_LUI:    begin rd_we = 1'b1; wd = imm_u; end
      OPC_AUIPC:  begin rd_we = 1'b1; wd = pc + imm_u; end
      OPC_JAL:    begin rd_we = 1'b1; wd = pc_plus4; pc_next = pc + imm_j; end
      OPC_JALR:   begin rd_we = 1'b1; wd = pc_plus4; pc_next = {addr_i[31:1], 1'b0}; end
      OPC_BRANCH: begin if (br_taken) pc_next = pc + imm_b; end
      OPC_LOAD:   begin rd_we = 1'b1; wd = load_val; end
      OPC_OPIMM,
      OPC_OP:     begin rd_we = 1'b1; wd = alu_res; end
      default:    begin rd_we = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rd_we && rd != 5'd0) regs[rd] <= wd;
    end
  end

  // Data memory has no reset; it only holds its contents across a reset.
  always_ff @(posedge clk) begin
    if (!rst && is_store) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem[widx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

`ifdef RV32I_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (rd_we && rd != 5'd0) $display("PC=%h INST=%h rd=x%0d WD=%h", pc, inst, rd, wd);
      if (is_store) $display("ST addr=%h data=%h", mem_addr, st_data);
    end
  end
`else
  // Trace disabled: the core is fully synthesizable with no display output.
`endif

endmodule

// File: tb/tb_rv32i_top.sv
// Self-checking bench for rv32i_top: programs are poked into imem, expected state is queued and drained.
module tb_rv32i_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rv32i_top #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .IMEM_INIT("")) dut (
    .clk  (clk),
    .rst_n(rst_n)
  );

  typedef struct {
    string       tag;
    int          kind;   // 0 reg, 1 dmem word, 2 pc
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = 0; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = 1; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_pc(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = 2; e.idx = 0; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = dut.regs[e.idx];
        1:       obs = dut.dmem[e.idx];
        default: obs = dut.pc;
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] itype(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] addi(input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] imm);
    return itype(imm, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] rtype(input logic [31:0] f7, input logic [31:0] rs2, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] stype(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] btype(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] utype(input logic [31:0] imm20, input logic [31:0] rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] jtype(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    prog.delete();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_core(input int n);
    rst_n = 1'b1;
    run(n);
    rst_n = 1'b0;
  endtask

  initial begin
    // Arithmetic and compares; reset state and pc sequencing
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 0, -3));
    prog.push_back(rtype(0, 2, 1, 0, 3));
    prog.push_back(rtype(7'h20, 1, 2, 0, 4));
    prog.push_back(rtype(0, 1, 2, 2, 5));
    prog.push_back(rtype(0, 1, 2, 3, 6));
    load_prog();
    rst_n = 1'b1;
    run(2);
    exp_pc("rst_pc", 32'h0);
    for (int i = 0; i < 32; i++) exp_reg($sformatf("rst_x%0d", i), i, 32'h0);
    drain();
    rst_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_pc($sformatf("pc_step%0d", k), 32'(4 * k));
      run(1);
      drain();
    end
    exp_reg("add_x1", 1, 32'd5);
    exp_reg("add_x2", 2, 32'hFFFF_FFFD);
    exp_reg("add_x3", 3, 32'd2);
    exp_reg("sub_x4", 4, 32'hFFFF_FFF8);
    exp_reg("slt_x5", 5, 32'd1);
    exp_reg("sltu_x6", 6, 32'd0);
    drain();

    // Shifts and x0 write discard
    prog.push_back(utype(32'h80000, 1, 7'h37));
    prog.push_back(itype(32'h404, 1, 5, 2, 7'h13));
    prog.push_back(itype(32'h004, 1, 5, 3, 7'h13));
    prog.push_back(addi(0, 0, 7));
    load_prog();
    reset_core(2);
    run(4);
    exp_reg("lui_x1", 1, 32'h8000_0000);
    exp_reg("srai_x2", 2, 32'hF800_0000);
    exp_reg("srli_x3", 3, 32'h0800_0000);
    exp_reg("x0_zero", 0, 32'h0);
    exp_pc("shift_pc", 32'd16);
    drain();

    // Byte lanes, sign/zero extension, store-then-load, misaligned word store
    prog.push_back(addi(1, 0, 32'h7F));
    prog.push_back(stype(1, 1, 0, 0));
    prog.push_back(addi(2, 0, -1));
    prog.push_back(stype(2, 2, 0, 1));
    prog.push_back(itype(0, 0, 2, 3, 7'h03));
    prog.push_back(itype(1, 0, 0, 4, 7'h03));
    prog.push_back(itype(2, 0, 5, 5, 7'h03));
    prog.push_back(itype(2, 0, 1, 6, 7'h03));
    prog.push_back(itype(3, 0, 4, 7, 7'h03));
    prog.push_back(stype(4, 1, 0, 2));
    prog.push_back(itype(4, 0, 2, 8, 7'h03));
    prog.push_back(stype(9, 2, 0, 2));
    prog.push_back(itype(8, 0, 2, 9, 7'h03));
    load_prog();
    reset_core(2);
    run(13);
    exp_mem("dmem0", 0, 32'hFFFF_7F00);
    exp_reg("lw_x3", 3, 32'hFFFF_7F00);
    exp_reg("lb_x4", 4, 32'h0000_007F);
    exp_reg("lhu_x5", 5, 32'h0000_FFFF);
    exp_reg("lh_x6", 6, 32'hFFFF_FFFF);
    exp_reg("lbu_x7", 7, 32'h0000_00FF);
    exp_reg("st_ld_x8", 8, 32'h0000_007F);
    exp_mem("dmem2", 2, 32'hFFFF_FFFF);
    exp_reg("sw_mis_x9", 9, 32'hFFFF_FFFF);
    drain();

    // Countdown loop with BNE and JAL skip
    prog.push_back(addi(1, 0, 3));
    prog.push_back(addi(1, 1, -1));
    prog.push_back(addi(5, 5, 1));
    prog.push_back(btype(-8, 0, 1, 1));
    prog.push_back(jtype(8, 2));
    prog.push_back(addi(3, 0, 9));
    prog.push_back(addi(6, 0, 1));
    load_prog();
    reset_core(2);
    run(12);
    exp_reg("loop_x1", 1, 32'd0);
    exp_reg("loop_cnt", 5, 32'd3);
    exp_reg("jal_link", 2, 32'd20);
    exp_reg("jal_skip", 3, 32'd0);
    exp_reg("jal_tgt", 6, 32'd1);
    exp_pc("loop_pc", 32'd28);
    drain();

    // Signed/unsigned branches and misc ALU
    prog.push_back(addi(1, 0, -1));
    prog.push_back(addi(2, 0, 1));
    prog.push_back(btype(8, 2, 1, 4));
    prog.push_back(addi(3, 0, 1));
    prog.push_back(btype(8, 2, 1, 6));
    prog.push_back(addi(4, 0, 1));
    prog.push_back(btype(8, 2, 1, 7));
    prog.push_back(addi(5, 0, 1));
    prog.push_back(btype(8, 1, 1, 0));
    prog.push_back(addi(6, 0, 1));
    prog.push_back(rtype(0, 2, 1, 4, 7));
    prog.push_back(itype(-1, 2, 3, 8, 7'h13));
    prog.push_back(utype(1, 9, 7'h17));
    prog.push_back(rtype(0, 1, 2, 1, 10));
    prog.push_back(itype(32'h0F0, 1, 7, 11, 7'h13));
    prog.push_back(itype(-16, 0, 6, 12, 7'h13));
    load_prog();
    reset_core(2);
    run(13);
    exp_reg("blt_skip", 3, 32'd0);
    exp_reg("bltu_fall", 4, 32'd1);
    exp_reg("bgeu_skip", 5, 32'd0);
    exp_reg("beq_skip", 6, 32'd0);
    exp_reg("xor_x7", 7, 32'hFFFF_FFFE);
    exp_reg("sltiu_x8", 8, 32'd1);
    exp_reg("auipc_x9", 9, 32'h0000_1030);
    exp_reg("sll_x10", 10, 32'h8000_0000);
    exp_reg("andi_x11", 11, 32'h0000_00F0);
    exp_reg("ori_x12", 12, 32'hFFFF_FFF0);
    exp_pc("br_pc", 32'd64);
    drain();

    // JALR with odd target, then reset mid-loop
    prog.push_back(addi(2, 0, 32'h40));
    prog.push_back(itype(1, 2, 0, 1, 7'h67));
    for (int i = 2; i < 16; i++) prog.push_back(32'h0000_0013);
    prog.push_back(addi(3, 3, 1));
    prog.push_back(jtype(-4, 0));
    load_prog();
    reset_core(2);
    run(2);
    exp_pc("jalr_pc", 32'h40);
    exp_reg("jalr_link", 1, 32'd8);
    drain();
    run(4);
    exp_reg("loop_x3", 3, 32'd2);
    exp_pc("loop_back", 32'h40);
    drain();
    reset_core(1);
    exp_pc("mid_rst_pc", 32'h0);
    exp_reg("mid_rst_x1", 1, 32'h0);
    exp_reg("mid_rst_x2", 2, 32'h0);
    exp_reg("mid_rst_x3", 3, 32'h0);
    exp_mem("keep_dmem0", 0, 32'hFFFF_7F00);
    exp_mem("keep_dmem2", 2, 32'hFFFF_FFFF);
    drain();
    run(1);
    exp_pc("restart_pc", 32'd4);
    exp_reg("restart_x2", 2, 32'h40);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
